// File: rtl/rca16_byte_loader.sv
// -----------------------------------------------------------------------------
// rca16_byte_loader
//
// Operand front end and result capture stage for an external 16-bit
// ripple-carry adder. Four bytes arriving on a valid/ready stream are
// assembled into operands A and B, which drive the adder directly. After a
// programmable settle interval the adder's sum and carry-out are registered
// and offered downstream on a second valid/ready handshake. Transactions do
// not overlap: the byte stream is stalled until the result has been taken.
//
// Parameters
//   BYTE_ORDER     0 = low byte of each operand first, 1 = high byte first
//   SETTLE_CYCLES  cycles from the final operand byte to result capture
//                  (1..15; 0 behaves as 1, larger values saturate at 15)
//
// Ports
//   clk        in   1   clock, all state updates on the rising edge
//   rst        in   1   synchronous active-high reset
//   in_data    in   8   operand byte
//   in_valid   in   1   in_data is valid
//   in_ready   out  1   a byte is accepted this cycle (state LOAD)
//   add_a      out  16  operand A to the adder
//   add_b      out  16  operand B to the adder
//   add_sum    in   16  adder sum
//   add_carry  in   1   adder carry-out
//   out_sum    out  16  registered sum
//   out_carry  out  1   registered carry-out
//   out_valid  out  1   result is valid (state HOLD)
//   out_ready  in   1   downstream accepts the result
// -----------------------------------------------------------------------------
module rca16_byte_loader #(
   parameter int BYTE_ORDER    = 0,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] add_a,
   output logic [15:0] add_b,
   input  logic [15:0] add_sum,
   input  logic        add_carry,
   output logic [15:0] out_sum,
   output logic        out_carry,
   output logic        out_valid,
   input  logic        out_ready
);

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   // Clamp the settle interval to what the 4-bit counter can express.
   localparam int SETTLE_EFF = (SETTLE_CYCLES < 1)  ? 1  :
                               (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
   // The counter is loaded on the byte-3 edge and captures when it reads 0,
   // so the capture edge lands SETTLE_EFF edges after the final byte.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_EFF - 1);

   state_t     state;
   logic [1:0] byte_cnt;
   logic [3:0] settle_cnt;
   logic [1:0] lane;
   logic       byte_fire;

   // Handshake flags decode straight from the state register, so they are
   // glitch-free and can never both be high.
   assign in_ready  = (state == LOAD);
   assign out_valid = (state == HOLD);
   assign byte_fire = in_valid && in_ready;

   // Operand lane for the current byte: bit 1 selects operand B, bit 0 the
   // high byte. High-byte-first order just swaps the two halves of each
   // operand, which is a flip of bit 0.
   assign lane = (BYTE_ORDER != 0) ? (byte_cnt ^ 2'b01) : byte_cnt;

   // NOTE: every register here, including the operand and result registers,
   // is reset and assigned with non-blocking assignments so that all state
   // updates on an edge see the values from before that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= LOAD;
         byte_cnt   <= 2'd0;
         settle_cnt <= 4'd0;
         add_a      <= 16'h0000;
         add_b      <= 16'h0000;
         out_sum    <= 16'h0000;
         out_carry  <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (byte_fire) begin
                  // Only the addressed lane changes; the rest of both
                  // operands keeps its previous contents.
                  case (lane)
                     2'd0:    add_a[7:0]  <= in_data;
                     2'd1:    add_a[15:8] <= in_data;
                     2'd2:    add_b[7:0]  <= in_data;
                     default: add_b[15:8] <= in_data;
                  endcase

                  if (byte_cnt == 2'd3) begin
                     byte_cnt   <= 2'd0;
                     settle_cnt <= SETTLE_LOAD;
                     state      <= SETTLE;
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
            end

            SETTLE: begin
               // Operands have been stable since the byte-3 edge; in_data is
               // ignored because in_ready is low here.
               if (settle_cnt == 4'd0) begin
                  out_sum   <= add_sum;
                  out_carry <= add_carry;
                  state     <= HOLD;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end

            HOLD: begin
               // Result and operands are frozen until downstream takes it;
               // out_sum/out_carry keep their values after the handshake.
               if (out_ready) begin
                  state <= LOAD;
               end
            end

            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rca16_byte_loader.sv
// -----------------------------------------------------------------------------
// tb_rca16_byte_loader
//
// Two instances are exercised: dut0 (low byte first, 1 settle cycle) and
// dut1 (high byte first, 3 settle cycles). Only the selected instance sees
// in_valid/out_ready. Each instance is paired with a behavioural stand-in for
// the external ripple-carry adder. Expected operands and results come from a
// model that rebuilds the operands from the byte list with plain arithmetic.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_rca16_byte_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       out_ready;
   bit         sel;

   logic        in_valid_v  [2];
   logic        in_ready_v  [2];
   logic        out_ready_v [2];
   logic        add_carry_v [2];
   logic        out_carry_v [2];
   logic        out_valid_v [2];
   logic [15:0] add_a_v     [2];
   logic [15:0] add_b_v     [2];
   logic [15:0] add_sum_v   [2];
   logic [15:0] out_sum_v   [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign in_valid_v[0]  = in_valid  && (sel == 1'b0);
   assign in_valid_v[1]  = in_valid  && (sel == 1'b1);
   assign out_ready_v[0] = out_ready && (sel == 1'b0);
   assign out_ready_v[1] = out_ready && (sel == 1'b1);

   // Stand-ins for the external adders.
   assign {add_carry_v[0], add_sum_v[0]} = 17'(add_a_v[0]) + 17'(add_b_v[0]);
   assign {add_carry_v[1], add_sum_v[1]} = 17'(add_a_v[1]) + 17'(add_b_v[1]);

   rca16_byte_loader #(.BYTE_ORDER(0), .SETTLE_CYCLES(1)) dut0 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid_v[0]),
      .in_ready  (in_ready_v[0]),
      .add_a     (add_a_v[0]),
      .add_b     (add_b_v[0]),
      .add_sum   (add_sum_v[0]),
      .add_carry (add_carry_v[0]),
      .out_sum   (out_sum_v[0]),
      .out_carry (out_carry_v[0]),
      .out_valid (out_valid_v[0]),
      .out_ready (out_ready_v[0])
   );

   rca16_byte_loader #(.BYTE_ORDER(1), .SETTLE_CYCLES(3)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid_v[1]),
      .in_ready  (in_ready_v[1]),
      .add_a     (add_a_v[1]),
      .add_b     (add_b_v[1]),
      .add_sum   (add_sum_v[1]),
      .add_carry (add_carry_v[1]),
      .out_sum   (out_sum_v[1]),
      .out_carry (out_carry_v[1]),
      .out_valid (out_valid_v[1]),
      .out_ready (out_ready_v[1])
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, sel, observed, expected);
      end
   endtask

   function automatic int settle_of(input bit s);
      return s ? 3 : 1;
   endfunction

   // Reference model: byte list -> operands -> 17-bit unsigned sum.
   task automatic model(input bit order, input logic [7:0] b0, b1, b2, b3,
                        output logic [15:0] ea, eb, es, output logic ec);
      int a_val, b_val, total;
      if (order == 1'b0) begin
         a_val = int'(b1) * 256 + int'(b0);
         b_val = int'(b3) * 256 + int'(b2);
      end else begin
         a_val = int'(b0) * 256 + int'(b1);
         b_val = int'(b2) * 256 + int'(b3);
      end
      total = a_val + b_val;
      ea = 16'(a_val);
      eb = 16'(b_val);
      es = 16'(total % 65536);
      ec = (total >= 65536);
   endtask

   // Present one byte and return at the falling edge after it was accepted.
   task automatic send_byte(input logic [7:0] b);
      int n;
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready_v[sel] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         failures++;
         $error("FAIL in_ready_timeout dut%0d observed=0 expected=1", sel);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_four(input logic [7:0] b0, b1, b2, b3);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      send_byte(b3);
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready",  32'(in_ready_v[sel]),  32'd1);
      check("rst_out_valid", 32'(out_valid_v[sel]), 32'd0);
      check("rst_add_a",     32'(add_a_v[sel]),     32'd0);
      check("rst_add_b",     32'(add_b_v[sel]),     32'd0);
      check("rst_out_sum",   32'(out_sum_v[sel]),   32'd0);
      check("rst_out_carry", 32'(out_carry_v[sel]), 32'd0);
   endtask

   // Full transaction with exact capture timing. gap = idle cycles before each
   // byte; hold = cycles of backpressure in HOLD; pend = keep 0xAA offered
   // upstream during backpressure (left pending on return).
   task automatic run_txn(input logic [7:0] b0, b1, b2, b3, input int gap,
                          input int hold, input bit pend,
                          output logic [15:0] es_out);
      logic [15:0] ea, eb, es;
      logic        ec;
      logic [7:0]  bytes [4];
      int          s;
      bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
      s = settle_of(sel);
      model(sel, b0, b1, b2, b3, ea, eb, es, ec);
      es_out = es;
      out_ready = (hold == 0);
      for (int i = 0; i < 4; i++) begin
         if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
         send_byte(bytes[i]);
      end
      in_valid = 1'b0;
      check("add_a", 32'(add_a_v[sel]), 32'(ea));
      check("add_b", 32'(add_b_v[sel]), 32'(eb));
      check("settle_valid", 32'(out_valid_v[sel]), 32'd0);
      for (int j = 1; j <= s; j++) begin
         @(negedge clk);
         if (j < s) begin
            check("settle_valid", 32'(out_valid_v[sel]), 32'd0);
         end else begin
            check("capture_valid",    32'(out_valid_v[sel]), 32'd1);
            check("capture_in_ready", 32'(in_ready_v[sel]),  32'd0);
            check("out_sum",          32'(out_sum_v[sel]),   32'(es));
            check("out_carry",        32'(out_carry_v[sel]), 32'(ec));
         end
      end
      if (hold > 0) begin
         if (pend) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
         end
         repeat (hold) begin
            @(negedge clk);
            check("hold_valid",    32'(out_valid_v[sel]), 32'd1);
            check("hold_sum",      32'(out_sum_v[sel]),   32'(es));
            check("hold_add_a",    32'(add_a_v[sel]),     32'(ea));
            check("hold_in_ready", 32'(in_ready_v[sel]),  32'd0);
         end
         out_ready = 1'b1;
      end
      @(negedge clk);
      check("post_valid",    32'(out_valid_v[sel]), 32'd0);
      check("post_in_ready", 32'(in_ready_v[sel]),  32'd1);
      check("post_sum_kept", 32'(out_sum_v[sel]),   32'(es));
      check("post_add_a",    32'(add_a_v[sel]),     32'(ea));
   endtask

   initial begin
      logic [15:0] es;
      logic [7:0]  r0, r1, r2, r3;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      sel       = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state of both instances.
      for (int k = 0; k < 2; k++) begin
         sel = 1'(k);
         check("init_in_ready",  32'(in_ready_v[sel]),  32'd1);
         check("init_out_valid", 32'(out_valid_v[sel]), 32'd0);
         check("init_add_a",     32'(add_a_v[sel]),     32'd0);
         check("init_out_sum",   32'(out_sum_v[sel]),   32'd0);
      end

      // Basic low-byte-first transaction.
      sel = 1'b0;
      run_txn(8'h34, 8'h12, 8'h78, 8'h56, 0, 0, 1'b0, es);
      check("basic_sum_const", 32'(out_sum_v[0]), 32'h68AC);

      // Wrap-around into the carry.
      run_txn(8'hFF, 8'hFF, 8'h01, 8'h00, 0, 0, 1'b0, es);
      check("wrap_carry_const", 32'(out_carry_v[0]), 32'd1);

      // Backpressure with 0xAA pending; 0xAA then becomes byte 0.
      run_txn(8'h11, 8'h22, 8'h33, 8'h44, 0, 5, 1'b1, es);
      run_txn(8'hAA, 8'h01, 8'h02, 8'h03, 0, 0, 1'b0, es);
      check("pend_lane", 32'(add_a_v[0][7:0]), 32'hAA);

      // Bubbles between bytes give the same result as the gap-free stream.
      run_txn(8'h34, 8'h12, 8'h78, 8'h56, 2, 0, 1'b0, es);

      // Reset mid-LOAD with a byte offered on the reset edge.
      send_byte(8'hEE);
      send_byte(8'hDD);
      in_data = 8'h77;
      do_reset();
      in_valid = 1'b0;
      run_txn(8'h01, 8'h00, 8'h02, 8'h00, 0, 0, 1'b0, es);
      check("rst_load_sum_const", 32'(out_sum_v[0]), 32'h0003);

      // High-byte-first instance, 3 settle cycles.
      sel = 1'b1;
      run_txn(8'h12, 8'h34, 8'h56, 8'h78, 0, 0, 1'b0, es);
      check("order1_sum_const", 32'(out_sum_v[1]), 32'h68AC);

      // Reset mid-SETTLE drops the pending result.
      out_ready = 1'b1;
      load_four(8'h90, 8'h80, 8'h70, 8'h60);
      @(negedge clk);
      do_reset();
      repeat (4) begin
         @(negedge clk);
         check("rst_settle_no_valid", 32'(out_valid_v[1]), 32'd0);
      end

      // Reset mid-HOLD.
      out_ready = 1'b0;
      load_four(8'h05, 8'h06, 8'h07, 8'h08);
      repeat (settle_of(sel)) @(negedge clk);
      check("pre_rst_hold_valid", 32'(out_valid_v[1]), 32'd1);
      do_reset();
      out_ready = 1'b1;
      run_txn(8'h00, 8'h01, 8'h00, 8'h02, 0, 0, 1'b0, es);

      // Randomized transactions on both instances.
      for (int t = 0; t < 24; t++) begin
         sel = 1'($urandom_range(0, 1));
         r0  = 8'($urandom);
         r1  = 8'($urandom);
         r2  = 8'($urandom);
         r3  = 8'($urandom);
         run_txn(r0, r1, r2, r3, int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)), 1'b0, es);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
